// File: rtl/cic_pkg.sv
// Shared constants, encodings and helpers for the CIC layer sequencer.
//   DW       : pixel / result data width
//   AW       : result memory address width
//   IMG_LOG2 : log2 of the image side; pooled side is half of it
package cic_pkg;

    localparam int unsigned DW        = 20;
    localparam int unsigned AW        = 12;
    localparam int unsigned IMG_LOG2  = 6;
    localparam int unsigned POOL_LOG2 = IMG_LOG2 - 1;

    // Result-memory bank select driven on csel
    typedef enum logic [2:0] {
        NSEL = 3'd0,
        L0K0 = 3'd1,
        L0K1 = 3'd2,
        L1K0 = 3'd3,
        L1K1 = 3'd4,
        L2F  = 3'd5
    } csel_e;

    typedef enum logic [3:0] {
        S_IDLE,
        S_CONV_REQ,
        S_CONV_WAIT,
        S_WR_K0,
        S_WR_K1,
        S_RD0,
        S_RD1,
        S_RD2,
        S_RD3,
        S_CAP,
        S_WR_L1,
        S_WR_L2,
        S_DONE
    } state_e;

    // Layer-0 address of one pixel of the 2x2 pooling window at (r, c)
    function automatic logic [AW-1:0] pool_rd_addr(
        input logic [POOL_LOG2-1:0] r,
        input logic [POOL_LOG2-1:0] c,
        input logic                 dy,
        input logic                 dx
    );
        return AW'({r, dy, c, dx});
    endfunction

endpackage

// File: rtl/cic_layer_sched_if.sv
// Conv-engine handshake plus result-memory port of the CIC sequencer.
//   master : sequencer side (drives conv_start/coords, crd/cwr/addresses/data/csel)
//   slave  : conv engine + result memory side
interface cic_layer_sched_if;
    import cic_pkg::*;

    logic                conv_start;
    logic [IMG_LOG2-1:0] conv_x;
    logic [IMG_LOG2-1:0] conv_y;
    logic                conv_done;
    logic [DW-1:0]       conv_res0;
    logic [DW-1:0]       conv_res1;

    logic                crd;
    logic [AW-1:0]       caddr_rd;
    logic [DW-1:0]       cdata_rd;
    logic                cwr;
    logic [AW-1:0]       caddr_wr;
    logic [DW-1:0]       cdata_wr;
    logic [2:0]          csel;

    modport master (
        output conv_start, conv_x, conv_y,
        input  conv_done, conv_res0, conv_res1,
        output crd, caddr_rd,
        input  cdata_rd,
        output cwr, caddr_wr, cdata_wr, csel
    );

    modport slave (
        input  conv_start, conv_x, conv_y,
        output conv_done, conv_res0, conv_res1,
        input  crd, caddr_rd,
        output cdata_rd,
        input  cwr, caddr_wr, cdata_wr, csel
    );

endinterface

// File: rtl/cic_maxpool4.sv
// Serial unsigned max over a stream of words.
//   in_valid : in_data is a word of the current window
//   seed     : this word starts a new window (replaces the running max)
//   max_q    : registered running max
//   max_c    : running max including the word presented this cycle
module cic_maxpool4
    import cic_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic          seed,
    input  logic [DW-1:0] in_data,
    output logic [DW-1:0] max_q,
    output logic [DW-1:0] max_c
);

    logic [DW-1:0] max_d;

    // Strict greater-than: on a tie the earlier word is kept
    always_comb begin
        max_d = max_q;
        if (in_valid) begin
            if (seed || (in_data > max_q)) begin
                max_d = in_data;
            end
        end
    end

    assign max_c = max_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            max_q <= '0;
        end else begin
            max_q <= max_d;
        end
    end

endmodule

// File: rtl/cic_layer_sched.sv
// Frame sequencer for the CIC datapath over a 64x64 frame.
//   clk, reset : clock, async active-low reset
//   ready/busy : frame handshake (ready sampled only in IDLE)
//   bus        : conv-engine request/response and result-memory port
// Conv phase: per pixel request the conv engine, write both kernel results
// to layer 0. Pool phase: per 2x2 window and kernel read 4 words, write the
// max to layer 1 and to the interleaved flatten area in layer 2.
module cic_layer_sched
    import cic_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              ready,
    output logic              busy,
    cic_layer_sched_if.master bus
);

    state_e                state_q, state_d;
    logic [IMG_LOG2-1:0]   x_q, x_d;
    logic [IMG_LOG2-1:0]   y_q, y_d;
    logic [POOL_LOG2-1:0]  r_q, r_d;
    logic [POOL_LOG2-1:0]  c_q, c_d;
    logic                  k_q, k_d;
    logic [DW-1:0]         res1_q, res1_d;

    logic                  busy_q, busy_d;
    logic                  conv_start_q, conv_start_d;
    logic                  crd_q, crd_d;
    logic [AW-1:0]         caddr_rd_q, caddr_rd_d;
    logic                  cwr_q, cwr_d;
    logic [AW-1:0]         caddr_wr_q, caddr_wr_d;
    logic [DW-1:0]         cdata_wr_q, cdata_wr_d;
    logic [2:0]            csel_q, csel_d;

    logic                  pool_valid;
    logic                  pool_seed;
    logic                  rd_dy;
    logic                  rd_dx;
    logic [DW-1:0]         pool_max_q;
    logic [DW-1:0]         pool_max_c;

    // Read data lags crd by one cycle, so window words arrive in RD1..CAP
    assign pool_valid = (state_q == S_RD1) || (state_q == S_RD2) ||
                        (state_q == S_RD3) || (state_q == S_CAP);
    assign pool_seed  = (state_q == S_RD1);

    cic_maxpool4 u_maxpool (
        .clk      (clk),
        .rst_n    (reset),
        .in_valid (pool_valid),
        .seed     (pool_seed),
        .in_data  (bus.cdata_rd),
        .max_q    (pool_max_q),
        .max_c    (pool_max_c)
    );

    // Next state and counters
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        r_d     = r_q;
        c_d     = c_q;
        k_d     = k_q;
        res1_d  = res1_q;

        unique case (state_q)
            S_IDLE: begin
                if (ready) begin
                    x_d     = '0;
                    y_d     = '0;
                    state_d = S_CONV_REQ;
                end
            end
            S_CONV_REQ: begin
                state_d = S_CONV_WAIT;
            end
            S_CONV_WAIT: begin
                if (bus.conv_done) begin
                    res1_d  = bus.conv_res1;
                    state_d = S_WR_K0;
                end
            end
            S_WR_K0: begin
                state_d = S_WR_K1;
            end
            S_WR_K1: begin
                x_d     = IMG_LOG2'(x_q + 1);
                state_d = S_CONV_REQ;
                if (x_q == '1) begin
                    y_d = IMG_LOG2'(y_q + 1);
                    if (y_q == '1) begin
                        r_d     = '0;
                        c_d     = '0;
                        k_d     = 1'b0;
                        state_d = S_RD0;
                    end
                end
            end
            S_RD0:   state_d = S_RD1;
            S_RD1:   state_d = S_RD2;
            S_RD2:   state_d = S_RD3;
            S_RD3:   state_d = S_CAP;
            S_CAP:   state_d = S_WR_L1;
            S_WR_L1: state_d = S_WR_L2;
            S_WR_L2: begin
                state_d = S_RD0;
                if (!k_q) begin
                    k_d = 1'b1;
                end else begin
                    k_d = 1'b0;
                    c_d = POOL_LOG2'(c_q + 1);
                    if (c_q == '1) begin
                        r_d = POOL_LOG2'(r_q + 1);
                        if (r_q == '1) begin
                            state_d = S_DONE;
                        end
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign rd_dy = (state_d == S_RD2) || (state_d == S_RD3);
    assign rd_dx = (state_d == S_RD1) || (state_d == S_RD3);

    // Registered outputs decoded from the state being entered
    always_comb begin
        busy_d       = !((state_d == S_IDLE) || (state_d == S_DONE));
        conv_start_d = 1'b0;
        crd_d        = 1'b0;
        caddr_rd_d   = caddr_rd_q;
        cwr_d        = 1'b0;
        caddr_wr_d   = caddr_wr_q;
        cdata_wr_d   = cdata_wr_q;
        csel_d       = NSEL;

        unique case (state_d)
            S_CONV_REQ: begin
                conv_start_d = 1'b1;
            end
            S_WR_K0: begin
                cwr_d      = 1'b1;
                csel_d     = L0K0;
                caddr_wr_d = AW'({y_d, x_d});
                cdata_wr_d = bus.conv_res0;
            end
            S_WR_K1: begin
                cwr_d      = 1'b1;
                csel_d     = L0K1;
                caddr_wr_d = AW'({y_d, x_d});
                cdata_wr_d = res1_q;
            end
            S_RD0, S_RD1, S_RD2, S_RD3: begin
                crd_d      = 1'b1;
                csel_d     = k_d ? L0K1 : L0K0;
                caddr_rd_d = pool_rd_addr(r_d, c_d, rd_dy, rd_dx);
            end
            S_WR_L1: begin
                // Last window word is on cdata_rd now; take the combined max
                cwr_d      = 1'b1;
                csel_d     = k_d ? L1K1 : L1K0;
                caddr_wr_d = AW'({r_d, c_d});
                cdata_wr_d = pool_max_c;
            end
            S_WR_L2: begin
                cwr_d      = 1'b1;
                csel_d     = L2F;
                caddr_wr_d = AW'({r_d, c_d, k_d});
                cdata_wr_d = pool_max_q;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            x_q          <= '0;
            y_q          <= '0;
            r_q          <= '0;
            c_q          <= '0;
            k_q          <= 1'b0;
            res1_q       <= '0;
            busy_q       <= 1'b0;
            conv_start_q <= 1'b0;
            crd_q        <= 1'b0;
            caddr_rd_q   <= '0;
            cwr_q        <= 1'b0;
            caddr_wr_q   <= '0;
            cdata_wr_q   <= '0;
            csel_q       <= '0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            r_q          <= r_d;
            c_q          <= c_d;
            k_q          <= k_d;
            res1_q       <= res1_d;
            busy_q       <= busy_d;
            conv_start_q <= conv_start_d;
            crd_q        <= crd_d;
            caddr_rd_q   <= caddr_rd_d;
            cwr_q        <= cwr_d;
            caddr_wr_q   <= caddr_wr_d;
            cdata_wr_q   <= cdata_wr_d;
            csel_q       <= csel_d;
        end
    end

    assign busy           = busy_q;
    assign bus.conv_start = conv_start_q;
    assign bus.conv_x     = x_q;
    assign bus.conv_y     = y_q;
    assign bus.crd        = crd_q;
    assign bus.caddr_rd   = caddr_rd_q;
    assign bus.cwr        = cwr_q;
    assign bus.caddr_wr   = caddr_wr_q;
    assign bus.cdata_wr   = cdata_wr_q;
    assign bus.csel       = csel_q;

endmodule

// File: tb/tb_cic_layer_sched.sv
// Scoreboard bench for cic_layer_sched: conv-engine model, preloaded
// layer-0 read image, expected write/read streams checked by a monitor.
module tb_cic_layer_sched;
    import cic_pkg::*;

    typedef struct {
        logic [2:0]    sel;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } xact_t;

    logic clk;
    logic reset;
    logic ready;
    logic busy;

    cic_layer_sched_if bus ();

    cic_layer_sched dut (
        .clk   (clk),
        .reset (reset),
        .ready (ready),
        .busy  (busy),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int conv_lat = 3;
    int n_wr = 0;
    int n_rd = 0;
    int overlaps = 0;
    int t_k0_first = -1;
    int t_k1_first = -1;
    int last_wr_cyc = 0;
    logic [DW-1:0] d_k0_first, d_k1_first;
    logic [DW-1:0] l1k0_0, l1k1_0, l2f_0, l2f_1;
    logic [2:0]    last_wr_sel;
    logic [AW-1:0] last_wr_addr;

    logic [DW-1:0] rom [2][4096];
    xact_t exp_wr[$];
    xact_t exp_rd[$];

    function automatic logic [DW-1:0] res0_of(int x, int y);
        if (x == 0 && y == 0) return 20'h00123;
        return DW'((y * 64 + x) * 5 + 1);
    endfunction

    function automatic logic [DW-1:0] res1_of(int x, int y);
        if (x == 0 && y == 0) return 20'h00456;
        return DW'(((y * 64 + x) * 7) ^ 32'h5A5A5);
    endfunction

    task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string pfx);
        check_eq({pfx, "_busy"},       32'(busy), 0);
        check_eq({pfx, "_conv_start"}, 32'(bus.conv_start), 0);
        check_eq({pfx, "_conv_x"},     32'(bus.conv_x), 0);
        check_eq({pfx, "_conv_y"},     32'(bus.conv_y), 0);
        check_eq({pfx, "_crd"},        32'(bus.crd), 0);
        check_eq({pfx, "_caddr_rd"},   32'(bus.caddr_rd), 0);
        check_eq({pfx, "_cwr"},        32'(bus.cwr), 0);
        check_eq({pfx, "_caddr_wr"},   32'(bus.caddr_wr), 0);
        check_eq({pfx, "_cdata_wr"},   32'(bus.cdata_wr), 0);
        check_eq({pfx, "_csel"},       32'(bus.csel), 0);
    endtask

    // Expected write and read streams for one complete frame
    task automatic push_frame();
        xact_t t;
        logic [DW-1:0] m, v;
        logic [AW-1:0] a;
        exp_wr.delete();
        exp_rd.delete();
        for (int y = 0; y < 64; y++) begin
            for (int x = 0; x < 64; x++) begin
                t.sel = 3'd1; t.addr = AW'(y * 64 + x); t.data = res0_of(x, y);
                exp_wr.push_back(t);
                t.sel = 3'd2; t.data = res1_of(x, y);
                exp_wr.push_back(t);
            end
        end
        for (int r = 0; r < 32; r++) begin
            for (int c = 0; c < 32; c++) begin
                for (int k = 0; k < 2; k++) begin
                    m = '0;
                    for (int i = 0; i < 4; i++) begin
                        a = AW'((2 * r + i / 2) * 64 + 2 * c + i % 2);
                        t.sel = 3'(1 + k); t.addr = a; t.data = '0;
                        exp_rd.push_back(t);
                        v = rom[k][a];
                        if (i == 0 || v > m) m = v;
                    end
                    t.sel = 3'(3 + k); t.addr = AW'(r * 32 + c); t.data = m;
                    exp_wr.push_back(t);
                    t.sel = 3'd5; t.addr = AW'((r * 32 + c) * 2 + k);
                    exp_wr.push_back(t);
                end
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Conv engine model: responds conv_lat cycles after conv_start (5 for pixel 0,0)
    initial begin
        int cx, cy, lat;
        bus.conv_done = 1'b0;
        bus.conv_res0 = '0;
        bus.conv_res1 = '0;
        forever begin
            @(negedge clk);
            if (reset && bus.conv_start) begin
                cx = int'(bus.conv_x);
                cy = int'(bus.conv_y);
                lat = (cx == 0 && cy == 0) ? 5 : conv_lat;
                repeat (lat) @(posedge clk);
                #1;
                bus.conv_done = 1'b1;
                bus.conv_res0 = res0_of(cx, cy);
                bus.conv_res1 = res1_of(cx, cy);
                @(posedge clk);
                #1;
                bus.conv_done = 1'b0;
                bus.conv_res0 = DW'($urandom);
                bus.conv_res1 = DW'($urandom);
            end
        end
    end

    // Result-memory read port: data valid the cycle after crd, garbage otherwise
    initial begin
        logic          pend;
        logic [AW-1:0] pa;
        logic [2:0]    ps;
        bus.cdata_rd = '0;
        forever begin
            @(negedge clk);
            pend = bus.crd;
            pa   = bus.caddr_rd;
            ps   = bus.csel;
            @(posedge clk);
            #1;
            if (pend) bus.cdata_rd = (ps == 3'd2) ? rom[1][pa] : rom[0][pa];
            else      bus.cdata_rd = DW'($urandom);
        end
    end

    // Monitor: pops the expected stream whenever the DUT reads or writes
    initial begin
        xact_t t;
        forever begin
            @(negedge clk);
            if (reset) begin
                if (bus.crd && bus.cwr) overlaps++;
                if (bus.cwr) begin
                    n_wr++;
                    checks++;
                    if (exp_wr.size() == 0) begin
                        errors++;
                        $display("FAIL wr_unexpected: sel=%0d addr=%h data=%h", bus.csel, bus.caddr_wr, bus.cdata_wr);
                    end else begin
                        t = exp_wr.pop_front();
                        if (bus.csel !== t.sel || bus.caddr_wr !== t.addr || bus.cdata_wr !== t.data) begin
                            errors++;
                            $display("FAIL wr_xact: got sel=%0d addr=%h data=%h, expected sel=%0d addr=%h data=%h",
                                     bus.csel, bus.caddr_wr, bus.cdata_wr, t.sel, t.addr, t.data);
                        end
                    end
                    if (bus.csel == 3'd1 && bus.caddr_wr == '0 && t_k0_first < 0) begin
                        t_k0_first = cyc; d_k0_first = bus.cdata_wr;
                    end
                    if (bus.csel == 3'd2 && bus.caddr_wr == '0 && t_k1_first < 0) begin
                        t_k1_first = cyc; d_k1_first = bus.cdata_wr;
                    end
                    if (bus.csel == 3'd3 && bus.caddr_wr == 12'h000) l1k0_0 = bus.cdata_wr;
                    if (bus.csel == 3'd4 && bus.caddr_wr == 12'h000) l1k1_0 = bus.cdata_wr;
                    if (bus.csel == 3'd5 && bus.caddr_wr == 12'h000) l2f_0 = bus.cdata_wr;
                    if (bus.csel == 3'd5 && bus.caddr_wr == 12'h001) l2f_1 = bus.cdata_wr;
                    last_wr_cyc  = cyc;
                    last_wr_sel  = bus.csel;
                    last_wr_addr = bus.caddr_wr;
                end
                if (bus.crd) begin
                    n_rd++;
                    checks++;
                    if (exp_rd.size() == 0) begin
                        errors++;
                        $display("FAIL rd_unexpected: sel=%0d addr=%h", bus.csel, bus.caddr_rd);
                    end else begin
                        t = exp_rd.pop_front();
                        if (bus.csel !== t.sel || bus.caddr_rd !== t.addr) begin
                            errors++;
                            $display("FAIL rd_xact: got sel=%0d addr=%h, expected sel=%0d addr=%h",
                                     bus.csel, bus.caddr_rd, t.sel, t.addr);
                        end
                    end
                end
            end
        end
    end

    initial begin
        int n;
        int drop_cyc;
        reset = 1'b0;
        ready = 1'b1;
        for (int k = 0; k < 2; k++)
            for (int a = 0; a < 4096; a++)
                rom[k][a] = DW'((a * 40503 + k * 977) ^ (a << 9));
        rom[0][12'h000] = 20'd5;
        rom[0][12'h001] = 20'd9;
        rom[0][12'h040] = 20'hFFFFF;
        rom[0][12'h041] = 20'd7;
        rom[1][12'h000] = 20'd3;
        rom[1][12'h001] = 20'h80000;
        rom[1][12'h040] = 20'h7FFFF;
        rom[1][12'h041] = 20'h80000;

        // Reset held with ready high
        repeat (3) @(negedge clk);
        check_all_zero("rst");

        // Frame 1: conv latency 3, ready toggling while busy
        push_frame();
        conv_lat = 3;
        reset = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!busy && n < 10);
        check_eq("busy_latency", 32'(n), 1);
        check_eq("first_conv_start", 32'(bus.conv_start), 1);
        check_eq("first_conv_x", 32'(bus.conv_x), 0);
        check_eq("first_conv_y", 32'(bus.conv_y), 0);

        n = 0;
        while (busy && n < 50000) begin
            ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            n++;
        end
        ready = 1'b0;
        drop_cyc = cyc;
        check_eq("frame1_timeout", 32'(n < 50000), 1);
        check_eq("cwr_count", 32'(n_wr), 12288);
        check_eq("crd_count", 32'(n_rd), 8192);
        check_eq("rd_wr_overlap", 32'(overlaps), 0);
        check_eq("exp_wr_left", 32'(exp_wr.size()), 0);
        check_eq("exp_rd_left", 32'(exp_rd.size()), 0);
        check_eq("k0_first_data", 32'(d_k0_first), 32'h00123);
        check_eq("k1_first_data", 32'(d_k1_first), 32'h00456);
        check_eq("k0_k1_consecutive", 32'(t_k1_first - t_k0_first), 1);
        check_eq("l1k0_addr0", 32'(l1k0_0), 32'hFFFFF);
        check_eq("l2f_addr0", 32'(l2f_0), 32'hFFFFF);
        check_eq("l1k1_addr0", 32'(l1k1_0), 32'h80000);
        check_eq("l2f_addr1", 32'(l2f_1), 32'h80000);
        check_eq("last_wr_sel", 32'(last_wr_sel), 5);
        check_eq("last_wr_addr", 32'(last_wr_addr), 32'h7FF);
        check_eq("busy_drop_after_last_wr", 32'(drop_cyc - last_wr_cyc), 1);

        repeat (4) @(negedge clk);
        check_eq("idle_busy", 32'(busy), 0);
        check_eq("idle_conv_start", 32'(bus.conv_start), 0);

        // Frame 2: conv latency 1, aborted by reset in RD2 of pool position 10
        push_frame();
        conv_lat = 1;
        ready = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!busy && n < 10);
        check_eq("f2_busy_latency", 32'(n), 1);
        ready = 1'b0;
        n = 0;
        while (!(bus.crd && bus.csel == 3'd1 && bus.caddr_rd == 12'h054) && n < 40000) begin
            @(negedge clk);
            n++;
        end
        check_eq("abort_point_reached", 32'(n < 40000), 1);
        #2;
        reset = 1'b0;
        #1;
        check_all_zero("abort");
        exp_wr.delete();
        exp_rd.delete();

        // Restart: next frame begins at conv (0,0)
        repeat (3) @(negedge clk);
        reset = 1'b1;
        ready = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!busy && n < 10);
        ready = 1'b0;
        check_eq("restart_busy_latency", 32'(n), 1);
        check_eq("restart_conv_start", 32'(bus.conv_start), 1);
        check_eq("restart_conv_x", 32'(bus.conv_x), 0);
        check_eq("restart_conv_y", 32'(bus.conv_y), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
